// File: rtl/uart_tx_fifo_pkg.sv
// Shared types and bus-decode constants for the UART transmit buffer.
package uart_tx_fifo_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_STRB,
    ST_WBUSY,
    ST_WRDY
  } tx_state_e;

  // CPU bus qualifier value that marks a data character (as opposed to control).
  localparam logic C_ND_DATA = 1'b0;

endpackage

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Byte-wide synchronous FIFO with a separate occupancy counter; a push while
// full is accepted only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [7:0]    din,
  output logic [7:0]    dout,
  output logic [AW:0]   cnt,
  output logic          full,
  output logic          empty
);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          push_ok, pop_ok;

  assign full  = (cnt_q == (AW+1)'(DEPTH));
  assign empty = (cnt_q == '0);
  assign cnt   = cnt_q;
  assign dout  = mem_q[rd_ptr_q];

  always_comb begin
    pop_ok   = pop & ~empty;
    push_ok  = push & (~full | pop_ok);
    wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop_ok  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    cnt_d    = cnt_q;
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// CPU-side transmit buffer: queues data writes and replays each byte to the
// UART transmitter as a single write strobe whenever it reports ready.
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned AW         = 4,
  parameter int unsigned STROBE_CYC = 2,
  parameter int unsigned BUSY_TO    = 32
) (
  input  logic          CLK50MHZ,
  input  logic          rst,
  input  logic          n_CS,
  input  logic          n_WR,
  input  logic          C_nD,
  input  logic [7:0]    DATA_IN,
  input  logic          clr_ovf,
  input  logic          Tx_RDY,
  output logic          tx_n_WR,
  output logic          tx_C_nD,
  output logic [7:0]    tx_DATA,
  output logic          fifo_full,
  output logic          fifo_empty,
  output logic [AW:0]   fifo_cnt,
  output logic          cpu_tx_rdy,
  output logic          ovf_fg
);

  localparam int unsigned TMAX = (BUSY_TO > STROBE_CYC) ? BUSY_TO : STROBE_CYC;
  localparam int unsigned TW   = $clog2(TMAX + 1);

  tx_state_e     state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          tx_n_wr_q, tx_n_wr_d;
  logic          tx_c_nd_q, tx_c_nd_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          wr_act_q, wr_act_d;
  logic          ovf_q, ovf_d;
  logic          push, pop;
  logic [7:0]    fifo_dout;

  sync_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk   (CLK50MHZ),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (DATA_IN),
    .dout  (fifo_dout),
    .cnt   (fifo_cnt),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // One push per CPU cycle: only the rising edge of the decoded write counts.
  always_comb begin
    wr_act_d = ~n_CS & ~n_WR & (C_nD == C_ND_DATA);
    push     = wr_act_d & ~wr_act_q;
  end

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty && Tx_RDY) begin
          state_d = ST_LOAD;
          pop     = 1'b1;
        end
      end
      ST_LOAD:  state_d = ST_STRB;
      ST_STRB:  if (timer_q == TW'(STROBE_CYC - 1)) state_d = ST_WBUSY;
      ST_WBUSY: begin
        if (!Tx_RDY)                           state_d = ST_WRDY;
        else if (timer_q == TW'(BUSY_TO - 1))  state_d = ST_IDLE;
      end
      ST_WRDY:  if (Tx_RDY) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    // Single timer shared by the strobe width and the busy timeout; cleared on entry.
    timer_d = '0;
    if (state_d == state_q && (state_q == ST_STRB || state_q == ST_WBUSY))
      timer_d = timer_q + TW'(1);

    tx_n_wr_d = (state_d != ST_STRB);
    tx_c_nd_d = (state_d == ST_STRB) ? C_ND_DATA : ~C_ND_DATA;
    tx_data_d = pop ? fifo_dout : tx_data_q;

    ovf_d = ovf_q;
    if (push && fifo_full && !pop) ovf_d = 1'b1;
    else if (clr_ovf)              ovf_d = 1'b0;
  end

  always_ff @(posedge CLK50MHZ) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      timer_q   <= '0;
      tx_n_wr_q <= 1'b1;
      tx_c_nd_q <= 1'b1;
      tx_data_q <= '0;
      wr_act_q  <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      tx_n_wr_q <= tx_n_wr_d;
      tx_c_nd_q <= tx_c_nd_d;
      tx_data_q <= tx_data_d;
      wr_act_q  <= wr_act_d;
      ovf_q     <= ovf_d;
    end
  end

  assign tx_n_WR    = tx_n_wr_q;
  assign tx_C_nD    = tx_c_nd_q;
  assign tx_DATA    = tx_data_q;
  assign ovf_fg     = ovf_q;
  assign cpu_tx_rdy = ~fifo_full;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: queue-based reference of the byte stream plus a
// behavioural Tx_top that goes busy after each strobe.
module tb_uart_tx_fifo;

  localparam int unsigned DEPTH      = 16;
  localparam int unsigned AW         = 4;
  localparam int unsigned STROBE_CYC = 2;
  localparam int unsigned BUSY_TO    = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          n_CS = 1'b1, n_WR = 1'b1, C_nD = 1'b1, clr_ovf = 1'b0, Tx_RDY = 1'b1;
  logic [7:0]    DATA_IN = '0;
  logic          tx_n_WR, tx_C_nD, fifo_full, fifo_empty, cpu_tx_rdy, ovf_fg;
  logic [7:0]    tx_DATA;
  logic [AW:0]   fifo_cnt;

  int unsigned   vec_cnt = 0, err_cnt = 0;
  logic [7:0]    exp_q[$];
  bit            m_ovf = 1'b0;
  bit            auto_mode = 1'b0, rdy_force = 1'b1;
  int unsigned   busy_len = 20, busy = 0;
  int unsigned   cyc = 0, strobes = 0, last_fall = 0, fall_gap = 0;
  bit            mon_prev = 1'b1, mon_abort = 1'b0;
  int unsigned   mon_run = 0;

  uart_tx_fifo #(
    .DEPTH      (DEPTH),
    .AW         (AW),
    .STROBE_CYC (STROBE_CYC),
    .BUSY_TO    (BUSY_TO)
  ) dut (
    .CLK50MHZ   (clk),
    .rst        (rst),
    .n_CS       (n_CS),
    .n_WR       (n_WR),
    .C_nD       (C_nD),
    .DATA_IN    (DATA_IN),
    .clr_ovf    (clr_ovf),
    .Tx_RDY     (Tx_RDY),
    .tx_n_WR    (tx_n_WR),
    .tx_C_nD    (tx_C_nD),
    .tx_DATA    (tx_DATA),
    .fifo_full  (fifo_full),
    .fifo_empty (fifo_empty),
    .fifo_cnt   (fifo_cnt),
    .cpu_tx_rdy (cpu_tx_rdy),
    .ovf_fg     (ovf_fg)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Transmitter model: busy for busy_len cycles after the last strobe cycle it sees.
  initial forever begin
    @(negedge clk); #1;
    if (auto_mode) begin
      if (tx_n_WR === 1'b0) busy = busy_len;
      else if (busy != 0)   busy--;
      Tx_RDY = (busy == 0);
    end else begin
      busy   = 0;
      Tx_RDY = rdy_force;
    end
  end

  // Strobe monitor: each falling tx_n_WR must carry the oldest queued byte.
  initial forever begin
    @(negedge clk); #2;
    if (mon_prev && tx_n_WR === 1'b0) begin
      mon_abort = rst;
      mon_run   = 1;
      fall_gap  = cyc - last_fall;
      last_fall = cyc;
      strobes++;
      chk("strb_c_nd", tx_C_nD, 1'b0);
      chk("strb_pending", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) chk("tx_data", tx_DATA, exp_q.pop_front());
    end else if (!mon_prev && tx_n_WR === 1'b0) begin
      mon_run++;
      if (rst) mon_abort = 1'b1;
    end else if (!mon_prev && tx_n_WR === 1'b1) begin
      if (!mon_abort) begin
        chk("strb_len", mon_run, STROBE_CYC);
        chk("idle_c_nd", tx_C_nD, 1'b1);
      end
    end
    mon_prev = (tx_n_WR !== 1'b0);
  end

  task automatic cpu_cycle(input logic cs_n, input logic cd, input logic [7:0] d,
                           input int unsigned hold, input bit pop_same, input bit set_rdy);
    @(negedge clk);
    n_CS = cs_n; C_nD = cd; n_WR = 1'b0; DATA_IN = d;
    if (set_rdy) rdy_force = 1'b1;
    if (!cs_n && !cd) begin
      if (exp_q.size() < DEPTH || pop_same) exp_q.push_back(d);
      else m_ovf = 1'b1;
    end
    repeat (hold) @(negedge clk);
    n_CS = 1'b1; n_WR = 1'b1; C_nD = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_drain(input int unsigned budget);
    int unsigned n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("drain_left", exp_q.size(), 0);
    repeat (64) @(negedge clk);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned s0, n;
    logic [7:0] b;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_n_wr", tx_n_WR, 1'b1);
    chk("rst_c_nd", tx_C_nD, 1'b1);
    chk("rst_data", tx_DATA, 8'h00);
    chk("rst_ovf", ovf_fg, 1'b0);
    chk("rst_empty", fifo_empty, 1'b1);
    chk("rst_full", fifo_full, 1'b0);
    chk("rst_cnt", fifo_cnt, 0);
    chk("rst_cpu_rdy", cpu_tx_rdy, 1'b1);
    rst = 1'b0;

    // Single byte latency: strobe low exactly 2 and 3 negedges after the push edge.
    auto_mode = 1'b1; busy_len = 20;
    cpu_cycle(1'b0, 1'b0, 8'hA5, 1, 1'b0, 1'b0);
    chk("t1_k1_nwr", tx_n_WR, 1'b1);
    @(negedge clk); chk("t1_k2_nwr", tx_n_WR, 1'b0); chk("t1_k2_data", tx_DATA, 8'hA5);
    @(negedge clk); chk("t1_k3_nwr", tx_n_WR, 1'b0);
    @(negedge clk); chk("t1_k4_nwr", tx_n_WR, 1'b1);
    wait_drain(200);
    chk("t1_empty", fifo_empty, 1'b1);

    // Fill with transmitter stalled, then overflow and clear.
    auto_mode = 1'b0; rdy_force = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 16; i++) cpu_cycle(1'b0, 1'b0, 8'(i), 1, 1'b0, 1'b0);
    chk("t2_cnt", fifo_cnt, exp_q.size());
    chk("t2_full", fifo_full, exp_q.size() == DEPTH);
    chk("t2_cpu_rdy", cpu_tx_rdy, exp_q.size() != DEPTH);
    chk("t2_empty", fifo_empty, exp_q.size() == 0);
    cpu_cycle(1'b0, 1'b0, 8'hFF, 1, 1'b0, 1'b0);
    chk("t2_ovf", ovf_fg, m_ovf);
    chk("t2_cnt_ovf", fifo_cnt, exp_q.size());
    clr_ovf = 1'b1; m_ovf = 1'b0;
    @(negedge clk); clr_ovf = 1'b0;
    chk("t2_clr", ovf_fg, m_ovf);
    @(negedge clk);
    n_CS = 1'b0; n_WR = 1'b0; C_nD = 1'b0; DATA_IN = 8'hEE; clr_ovf = 1'b1;
    if (exp_q.size() >= DEPTH) m_ovf = 1'b1; else exp_q.push_back(8'hEE);
    @(negedge clk);
    n_CS = 1'b1; n_WR = 1'b1; C_nD = 1'b1; clr_ovf = 1'b0;
    chk("t2_set_wins", ovf_fg, m_ovf);
    clr_ovf = 1'b1; m_ovf = 1'b0;
    @(negedge clk); clr_ovf = 1'b0;
    @(negedge clk);
    chk("t2_clr2", ovf_fg, m_ovf);

    // Drain with a busy transmitter.
    auto_mode = 1'b1; busy_len = 20; s0 = strobes;
    wait_drain(2000);
    chk("t3_strobes", strobes - s0, 16);
    chk("t3_cnt", fifo_cnt, 0);
    chk("t3_empty", fifo_empty, 1'b1);

    // Long write pulse and non-data cycles.
    auto_mode = 1'b0; rdy_force = 1'b0;
    @(negedge clk);
    cpu_cycle(1'b0, 1'b0, 8'h3C, 10, 1'b0, 1'b0);
    chk("t4_one_push", fifo_cnt, exp_q.size());
    cpu_cycle(1'b0, 1'b1, 8'h99, 3, 1'b0, 1'b0);
    cpu_cycle(1'b1, 1'b0, 8'h98, 3, 1'b0, 1'b0);
    chk("t4_no_push", fifo_cnt, exp_q.size());

    // Full FIFO: push lands on the same edge as the pop.
    for (int i = 1; i < 16; i++) cpu_cycle(1'b0, 1'b0, 8'($urandom), 1, 1'b0, 1'b0);
    chk("t5_full", fifo_full, exp_q.size() == DEPTH);
    cpu_cycle(1'b0, 1'b0, 8'hC3, 1, 1'b1, 1'b1);
    chk("t5_cnt", fifo_cnt, exp_q.size() - 1);
    chk("t5_ovf", ovf_fg, m_ovf);
    auto_mode = 1'b1;
    wait_drain(2000);

    // Transmitter never drops ready: timeout spacing between strobes.
    auto_mode = 1'b0; rdy_force = 1'b1; s0 = strobes;
    cpu_cycle(1'b0, 1'b0, 8'h5A, 1, 1'b0, 1'b0);
    cpu_cycle(1'b0, 1'b0, 8'h66, 1, 1'b0, 1'b0);
    n = 0;
    while (strobes - s0 < 2 && n < 300) begin @(negedge clk); n++; end
    @(negedge clk);
    chk("t6_strobes", strobes - s0, 2);
    chk("t6_gap", fall_gap, STROBE_CYC + BUSY_TO + 2);
    repeat (BUSY_TO + 8) @(negedge clk);

    // Reset while strobing.
    cpu_cycle(1'b0, 1'b0, 8'h11, 1, 1'b0, 1'b0);
    cpu_cycle(1'b0, 1'b0, 8'h22, 1, 1'b0, 1'b0);
    n = 0;
    while (tx_n_WR !== 1'b0 && n < 100) begin @(negedge clk); n++; end
    chk("t6_strb_seen", tx_n_WR, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rst_nwr", tx_n_WR, 1'b1);
    chk("t6_rst_cnt", fifo_cnt, 0);
    chk("t6_rst_empty", fifo_empty, 1'b1);
    rst = 1'b0;
    exp_q.delete();
    m_ovf = 1'b0;
    auto_mode = 1'b1; busy_len = 5;
    cpu_cycle(1'b0, 1'b0, 8'h77, 1, 1'b0, 1'b0);
    wait_drain(300);

    // Randomized traffic against the queue model.
    for (int r = 0; r < 60; r++) begin
      int unsigned kind;
      busy_len = $urandom_range(2, 25);
      n = 0;
      while (exp_q.size() >= 14 && n < 2000) begin @(negedge clk); n++; end
      if (n >= 2000) chk("rand_stall", exp_q.size(), 0);
      kind = $urandom_range(0, 9);
      b = 8'($urandom);
      cpu_cycle(kind == 0, kind == 1, b, $urandom_range(1, 4), 1'b0, 1'b0);
      repeat ($urandom_range(0, 6)) @(negedge clk);
    end
    wait_drain(5000);
    chk("rand_cnt", fifo_cnt, 0);
    chk("rand_empty", fifo_empty, 1'b1);
    chk("rand_ovf", ovf_fg, m_ovf);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
